// File: rtl/tt_um_hoene_manchester_word_decoder_if.sv
// Output bundle of the Manchester word decoder.
// Word, flags and the valid/ready handshake toward the consumer.
interface tt_um_hoene_manchester_word_decoder_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] out_word;
    logic              out_valid;
    logic              out_ready;
    logic              out_error;
    logic              out_overflow;

    modport master (
        output out_word,
        output out_valid,
        output out_error,
        output out_overflow,
        input  out_ready
    );

    modport slave (
        input  out_word,
        input  out_valid,
        input  out_error,
        input  out_overflow,
        output out_ready
    );
endinterface

// File: rtl/tt_um_hoene_manchester_word_decoder.sv
// Manchester decoder with programmable bit period.
// Synchronizes the line, classifies pulse widths and assembles words.
module tt_um_hoene_manchester_word_decoder #(
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic [CNT_W-1:0] bit_len,
    tt_um_hoene_manchester_word_decoder_if.master o_bus
);
    localparam int CW = CNT_W + 1;
    localparam int BW = $clog2(DATA_W + 1);

    logic              r_s1;
    logic              r_s2;
    logic              r_prev;
    logic [CW-1:0]     r_cnt;
    logic [BW-1:0]     r_bc;
    logic [DATA_W-1:0] r_sh;
    logic              r_mid;
    logic              r_err;
    logic [DATA_W-1:0] r_word;
    logic              r_valid;
    logic              r_ovf;

    logic [CW-1:0]     w_len;
    logic [CW-1:0]     w_l;
    logic [CW-1:0]     w_q;
    logic [CW-1:0]     w_t;
    logic [CW-1:0]     w_h;
    logic              w_edge;
    logic              w_long;
    logic              w_short;
    logic              w_bad;
    logic              w_tmo;
    logic              w_emit;
    logic              w_done;
    logic [DATA_W-1:0] w_word;

    assign w_len  = {1'b0, bit_len};
    assign w_l    = (w_len < CW'(4)) ? CW'(4) : w_len;
    assign w_q    = w_l >> 2;
    assign w_t    = w_l - w_q;
    assign w_h    = w_l + (w_l >> 1);
    assign w_edge = r_s2 ^ r_prev;

    // Pulse-width classification of the interval that ends at this edge
    always_comb begin
        w_long  = w_edge && (r_cnt >= w_t) && (r_cnt < w_h);
        w_short = w_edge && (r_cnt >= w_q) && (r_cnt < w_t) && !r_err;
        w_bad   = w_edge && !w_long && !w_short;
        w_tmo   = !w_edge && (r_cnt == w_h) && !r_err;
        w_emit  = w_long || (w_short && !r_mid);
        w_done  = w_emit && (r_bc == BW'(DATA_W - 1));
        w_word  = MSB_FIRST ? {r_sh[DATA_W-2:0], r_prev}
                            : {r_prev, r_sh[DATA_W-1:1]};
    end

    // Synchronizer, pulse counter, bit assembly and output handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= in;
            r_s2    <= in;
            r_prev  <= in;
            r_cnt   <= '0;
            r_bc    <= '0;
            r_sh    <= '0;
            r_mid   <= 1'b0;
            r_err   <= 1'b1;
            r_word  <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_s1   <= in;
            r_s2   <= r_s1;
            r_prev <= r_s2;
            r_ovf  <= 1'b0;
            if (w_edge) begin
                r_cnt <= '0;
            end else if (r_cnt < w_h) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (r_valid && o_bus.out_ready) begin
                r_valid <= 1'b0;
            end
            if (w_long) begin
                r_err <= 1'b0;
                r_mid <= 1'b1;
            end else if (w_short) begin
                r_mid <= ~r_mid;
            end else if (w_bad || w_tmo) begin
                r_err <= 1'b1;
                r_mid <= 1'b0;
                r_bc  <= '0;
                r_sh  <= '0;
            end
            if (w_emit) begin
                r_sh <= w_word;
                if (w_done) begin
                    r_bc <= '0;
                    if (!r_valid || o_bus.out_ready) begin
                        r_word  <= w_word;
                        r_valid <= 1'b1;
                    end else begin
                        r_ovf <= 1'b1;
                    end
                end else begin
                    r_bc <= r_bc + BW'(1);
                end
            end
        end
    end

    assign o_bus.out_word     = r_word;
    assign o_bus.out_valid    = r_valid;
    assign o_bus.out_error    = r_err;
    assign o_bus.out_overflow = r_ovf;
endmodule

// File: tb/tb_tt_um_hoene_manchester_word_decoder.sv
// Scoreboard bench for the Manchester word decoder.
// Drives one line into an MSB-first and an LSB-first instance.
module tb_tt_um_hoene_manchester_word_decoder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       line = 1'b0;
    logic [7:0] bit_len = 8'd24;

    int tests = 0;
    int fails = 0;
    int ovf_seen = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    tt_um_hoene_manchester_word_decoder_if #(.DATA_W(8)) m0 ();
    tt_um_hoene_manchester_word_decoder_if #(.DATA_W(8)) m1 ();

    tt_um_hoene_manchester_word_decoder #(
        .DATA_W(8), .CNT_W(8), .MSB_FIRST(1'b1)
    ) dut0 (
        .clk(clk), .rst(rst), .in(line), .bit_len(bit_len), .o_bus(m0)
    );

    tt_um_hoene_manchester_word_decoder #(
        .DATA_W(8), .CNT_W(8), .MSB_FIRST(1'b0)
    ) dut1 (
        .clk(clk), .rst(rst), .in(line), .bit_len(bit_len), .o_bus(m1)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endfunction

    function automatic logic [7:0] rev8(logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    task automatic hold(logic v, int n);
        line = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // first bit needs a full-period pulse of its own level to sync
    task automatic send_bits(logic [15:0] bits, int nb, int half);
        logic b0;
        logic b;
        b0 = bits[nb-1];
        if (line == b0) hold(~b0, half);
        hold(b0, half);
        for (int i = nb - 1; i >= 0; i--) begin
            b = bits[i];
            hold(b, half);
            hold(~b, half);
        end
    endtask

    task automatic send_word(logic [7:0] w, int half, bit drop0);
        if (!drop0) q0.push_back(w);
        q1.push_back(rev8(w));
        send_bits({8'h00, w}, 8, half);
    endtask

    // monitor for the MSB-first instance
    always @(negedge clk) begin
        if (!rst) begin
            if (m0.out_valid && m0.out_ready) begin
                if (q0.size() == 0) begin
                    chk("unexp_word0", {24'h0, m0.out_word}, 32'hFFFF_FFFF);
                end else begin
                    chk("word0", {24'h0, m0.out_word}, {24'h0, q0.pop_front()});
                end
            end
            if (m0.out_overflow) begin
                ovf_seen++;
                if (q0.size() != 0)
                    chk("held_word", {24'h0, m0.out_word}, {24'h0, q0[0]});
            end
        end
    end

    // monitor for the LSB-first instance
    always @(negedge clk) begin
        if (!rst) begin
            if (m1.out_valid && m1.out_ready) begin
                if (q1.size() == 0) begin
                    chk("unexp_word1", {24'h0, m1.out_word}, 32'hFFFF_FFFF);
                end else begin
                    chk("word1", {24'h0, m1.out_word}, {24'h0, q1.pop_front()});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m0.out_ready = 1'b1;
        m1.out_ready = 1'b1;
        rst = 1'b1;
        hold(1'b0, 2);
        chk("rst_err", {31'h0, m0.out_error}, 32'h1);
        chk("rst_valid", {31'h0, m0.out_valid}, 32'h0);
        chk("rst_word", {24'h0, m0.out_word}, 32'h0);
        chk("rst_ovf", {31'h0, m0.out_overflow}, 32'h0);
        rst = 1'b0;
        hold(1'b0, 10);

        send_word(8'hA5, 12, 1'b0);
        chk("sync_a5", {31'h0, m0.out_error}, 32'h0);
        hold(line, 60);
        chk("tmo_a5", {31'h0, m0.out_error}, 32'h1);
        chk("idle_valid", {31'h0, m0.out_valid}, 32'h0);

        q0.push_back(8'hA5);
        q1.push_back(8'hA5);
        send_bits({5'h0, 8'hA5, 3'b101}, 11, 12);
        hold(line, 60);
        chk("tmo_part", {31'h0, m0.out_error}, 32'h1);
        send_word(8'h3C, 12, 1'b0);
        hold(line, 60);

        m0.out_ready = 1'b0;
        send_word(8'h11, 12, 1'b0);
        hold(line, 60);
        send_word(8'h22, 12, 1'b1);
        hold(line, 60);
        chk("ovf_count", ovf_seen, 32'd1);
        chk("held_valid", {31'h0, m0.out_valid}, 32'h1);
        chk("held_11", {24'h0, m0.out_word}, 32'h11);
        m0.out_ready = 1'b1;
        hold(line, 3);
        chk("valid_fall", {31'h0, m0.out_valid}, 32'h0);

        send_bits(16'h000C, 4, 12);
        hold(~line, 4);
        hold(~line, 8);
        chk("glitch_err", {31'h0, m0.out_error}, 32'h1);
        send_word(8'h96, 12, 1'b0);
        hold(line, 60);

        bit_len = 8'd2;
        hold(line, 4);
        send_word(8'h5A, 2, 1'b0);
        hold(line, 20);
        chk("tmo_len2", {31'h0, m0.out_error}, 32'h1);

        bit_len = 8'd200;
        hold(line, 4);
        send_word(8'h5A, 100, 1'b0);
        chk("sync_len200", {31'h0, m0.out_error}, 32'h0);
        hold(line, 340);
        chk("tmo_len200", {31'h0, m0.out_error}, 32'h1);

        hold(line, 10);
        chk("q0_empty", q0.size(), 32'd0);
        chk("q1_empty", q1.size(), 32'd0);
        chk("ovf_final", ovf_seen, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
